// File: rtl/loader_pkg.sv
// Shared types and sizing helpers for the program loader and its byte packer.
package loader_pkg;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Counter width that stays legal even for single-byte words.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into one instruction word and tracks the byte position.
module byte_packer
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);

  localparam int             BPW      = bytes_per_word(DATA_W);
  localparam int             CW       = cnt_width(BPW);
  localparam logic [CW-1:0]  LAST_IDX = CW'(BPW - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (load_i) begin
      word_d = (word_q >> 8) | (DATA_W'(byte_i) << (DATA_W - 8));
      cnt_d  = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Writes a byte-streamed program image into instruction memory and holds the core in reset
// until the image is complete.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int HOLD_AT_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              pk_clear, pk_load, pk_last;
  logic [DATA_W-1:0] pk_word;

  // Zero requests the full memory; oversized requests saturate to it.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] wc);
    if (wc == '0 || wc > MAX_WORDS) return MAX_WORDS;
    return wc;
  endfunction

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (pk_clear),
    .load_i  (pk_load),
    .byte_i  (byte_data),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    done_d    = 1'b0;
    pk_clear  = 1'b0;
    pk_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_d     = clamp_count(word_count);
          idx_d     = '0;
          err_d     = 1'b0;
          cpu_rst_d = 1'b1;
          pk_clear  = 1'b1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (abort) begin
          err_d     = 1'b1;
          cpu_rst_d = 1'b1;
          pk_clear  = 1'b1;
          state_d   = IDLE;
        end else if (byte_valid) begin
          pk_load = 1'b1;
          if (pk_last) state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          err_d     = 1'b1;
          cpu_rst_d = 1'b1;
          pk_clear  = 1'b1;
          state_d   = IDLE;
        end else if ({1'b0, idx_q} == cnt_q - 1'b1) begin
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
          state_d   = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      cpu_rst_q <= 1'(HOLD_AT_RESET);
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cpu_rst_q <= cpu_rst_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign byte_ready = (state_q == RECV);
  assign imem_we    = (state_q == WRITE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign imem_addr  = idx_q;
  assign imem_wdata = pk_word;
  assign cpu_rst    = cpu_rst_q;
  assign err        = err_q;
  assign done       = done_q;

endmodule
